// File: rtl/axis_pack.sv
// axis_pack: gathers PACK_RATIO narrow samples from an AXI-stream slave into
// one wide word presented on a registered AXI-stream master. A sample with
// s_axis_tlast set flushes the partially filled word. Unfilled lanes of a
// flushed word are zero and their tkeep bits are cleared.
//
// Ports
//   clk, rst_n        single clock; asynchronous active-low reset
//   s_axis_tvalid     input sample valid
//   s_axis_tready     block accepts a sample
//   s_axis_tdata      input sample (one lane, SAMPLE_WIDTH bits)
//   s_axis_tlast      last sample of a packet; forces a flush
//   m_axis_tvalid     packed word valid
//   m_axis_tready     downstream accepts the word
//   m_axis_tdata      packed word; lane k = bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   m_axis_tkeep      one bit per lane; 1 = lane holds a real sample
//   m_axis_tlast      word closes a packet
module axis_pack #(
  parameter  int unsigned SAMPLE_WIDTH = 32,
  parameter  int unsigned PACK_RATIO   = 8,
  localparam int unsigned DATA_WIDTH   = SAMPLE_WIDTH * PACK_RATIO,
  localparam int unsigned COUNT_WIDTH  = $clog2(PACK_RATIO)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [SAMPLE_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [PACK_RATIO-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast
);

  localparam logic [COUNT_WIDTH-1:0] LAST_LANE = COUNT_WIDTH'(PACK_RATIO - 1);

  logic                   run_q;
  logic [COUNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0]  acc_q,    acc_d;
  logic [PACK_RATIO-1:0]  kacc_q,   kacc_d;
  logic                   tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]  tdata_q,  tdata_d;
  logic [PACK_RATIO-1:0]  tkeep_q,  tkeep_d;
  logic                   tlast_q,  tlast_d;

  logic                   s_frame;
  logic                   m_frame;
  logic                   complete;
  logic [DATA_WIDTH-1:0]  word_ins;
  logic [PACK_RATIO-1:0]  keep_ins;

  assign s_axis_tready = run_q & (~tvalid_q | m_axis_tready);
  assign s_frame       = s_axis_tvalid & s_axis_tready;
  assign m_frame       = tvalid_q & m_axis_tready;
  assign complete      = s_frame & ((cnt_q == LAST_LANE) | s_axis_tlast);

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;

  // Accumulator and keep mask with the incoming sample dropped into lane cnt.
  // Shared by the completing and non-completing paths.
  always_comb begin
    word_ins = acc_q;
    keep_ins = kacc_q;
    for (int unsigned k = 0; k < PACK_RATIO; k++) begin
      if (cnt_q == COUNT_WIDTH'(k)) begin
        word_ins[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_axis_tdata;
        keep_ins[k]                              = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    kacc_d   = kacc_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;

    if (m_frame) begin
      tvalid_d = 1'b0;
    end

    // A completion overrides the drain above so back-to-back words have no bubble.
    if (complete) begin
      tdata_d  = word_ins;
      tkeep_d  = keep_ins;
      tlast_d  = s_axis_tlast;
      tvalid_d = 1'b1;
      acc_d    = '0;
      kacc_d   = '0;
      cnt_d    = '0;
    end else if (s_frame) begin
      acc_d    = word_ins;
      kacc_d   = keep_ins;
      cnt_d    = cnt_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      kacc_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      kacc_q   <= kacc_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
    end
  end

endmodule

// File: tb/tb_axis_pack.sv
module tb_axis_pack;

  localparam int SW = 32;
  localparam int PR = 8;
  localparam int DW = SW * PR;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic          s_tready;
  logic [SW-1:0] s_tdata;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [PR-1:0] m_tkeep;
  logic          m_tlast;

  axis_pack #(.SAMPLE_WIDTH(SW), .PACK_RATIO(PR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [PR-1:0] keep;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [SW-1:0] cur[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            bp_mode  = 0;  // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: collect accepted samples of the current word; a word is
  // emitted once PR samples are collected or a sample carries tlast.
  task automatic model_accept(input logic [SW-1:0] d, input logic l);
    word_t w;
    cur.push_back(d);
    if (cur.size() == PR || l) begin
      w.data = '0;
      w.keep = '0;
      for (int i = 0; i < cur.size(); i++) begin
        w.data[i*SW +: SW] = cur[i];
        w.keep[i]          = 1'b1;
      end
      w.last = l;
      exp_q.push_back(w);
      cur.delete();
    end
  endtask

  task automatic send(input logic [SW-1:0] d, input logic l, output int tries);
    bit done = 0;
    tries = 0;
    while (!done) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      tries++;
      #1;
      if (s_tready) begin
        model_accept(d, l);
        done = 1;
        @(posedge clk);
        #1;
      end else if (tries > 500) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no s_axis_tready expected handshake within 500 cycles");
        done = 1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending_words", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, m_tvalid, 0);
    chk({tag, "_m_tdata"},  m_tdata,  0);
    chk({tag, "_m_tkeep"},  m_tkeep,  0);
    chk({tag, "_m_tlast"},  m_tlast,  0);
    chk({tag, "_s_tready"}, s_tready, 0);
  endtask

  // Monitor: drives m_tready, pops the scoreboard on every output handshake
  // and checks backpressure invariants.
  initial begin
    word_t         w;
    bit            hold = 0;
    logic [DW-1:0] h_data;
    logic [PR-1:0] h_keep;
    logic          h_last;
    m_tready = 1'b0;
    forever begin
      @(negedge clk);
      m_tready = (bp_mode == 0) ? 1'b1 :
                 (bp_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      if (!rst_n) begin
        hold = 0;
      end else begin
        #2;
        if (hold) begin
          chk("hold_tvalid", m_tvalid, 1);
          chk("hold_tdata",  m_tdata,  h_data);
          chk("hold_tkeep",  m_tkeep,  h_keep);
          chk("hold_tlast",  m_tlast,  h_last);
        end
        if (m_tvalid) begin
          chk("tkeep_contiguous", (m_tkeep & (m_tkeep + 1'b1)), 0);
          if (!m_tready) chk("bp_s_tready", s_tready, 0);
        end
        if (m_tvalid && m_tready) begin
          hold = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got tdata %0h tkeep %0h expected no word", m_tdata, m_tkeep);
          end else begin
            w = exp_q.pop_front();
            chk("word_tdata", m_tdata, w.data);
            chk("word_tkeep", m_tkeep, w.keep);
            chk("word_tlast", m_tlast, w.last);
          end
        end else if (m_tvalid) begin
          hold   = 1;
          h_data = m_tdata;
          h_keep = m_tkeep;
          h_last = m_tlast;
        end else begin
          hold = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    bp_mode  = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_tready_first_cycle", s_tready, 0);
    @(posedge clk);
    #1;
    chk("s_tready_after_run", s_tready, 1);

    // Full word, latency and gapless acceptance of the next word.
    for (int i = 1; i <= 8; i++) send(SW'(i), 1'b0, t);
    chk("full_word_latency", m_tvalid, 1);
    send(32'd9, 1'b0, t);
    chk("no_gap_sample9_tries", t, 1);
    for (int i = 10; i <= 16; i++) send(SW'(i), 1'b0, t);
    drain();

    // Partial flush, tlast on full boundary, single-sample packet.
    send(32'hA, 1'b0, t);
    send(32'hB, 1'b0, t);
    send(32'hC, 1'b1, t);
    drain();
    for (int i = 0; i < 8; i++) send(32'h200 + SW'(i), (i == 7), t);
    drain();
    send(32'h5A, 1'b1, t);
    drain();

    // Backpressure: word pending with downstream stalled for 10 cycles.
    bp_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(32'h300 + SW'(i), 1'b0, t);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_stall_s_tready", s_tready, 0);
      chk("bp_stall_tvalid",   m_tvalid, 1);
      chk("bp_stall_tdata",    m_tdata,  exp_q[0].data);
    end
    #3;
    bp_mode = 0;
    @(negedge clk);
    #1;
    chk("bp_release_s_tready", s_tready, 1);
    drain();

    // Randomized traffic with random downstream backpressure.
    bp_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      else send($urandom, ($urandom_range(0, 5) == 0), t);
    end
    send($urandom, 1'b1, t);
    drain();

    // Asynchronous reset mid-word discards the partial word.
    bp_mode = 0;
    for (int i = 0; i < 5; i++) send(32'h400 + SW'(i), 1'b0, t);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    cur.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_s_tready_low", s_tready, 0);
    @(posedge clk);
    #1;
    chk("post_reset_s_tready_high", s_tready, 1);
    for (int i = 0; i < 8; i++) send(32'h500 + SW'(i), 1'b0, t);
    drain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
